fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the single-issue RV32I pipeline. Owns the program counter and drives the byte address of the combinational instruction ROM, which returns the 32-bit word assembled big-endian from four consecutive bytes. Registers the returned word into the IF/ID pipeline register for decode. Handles stall, control-flow redirect, misaligned targets, out-of-range fetch and a fetch counter.

## Interface
Parameters:
- WIDTH, 32, address and instruction width
- RESET_PC, 32'h0, PC value loaded on reset
- ROM_BYTES, 4096, ROM size in bytes; highest legal fetch address is ROM_BYTES-4
- NOP, 32'h00000013, bubble word (addi x0,x0,0)
- CNT_W, 32, fetch counter width

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_n_i  in  1  reset, synchronous, active-low
- stall_i  in  1  hold PC and IF/ID contents
- redirect_i  in  1  taken branch/jump from a later stage
- target_i  in  WIDTH  redirect byte address
- instr_addr_o  out  WIDTH  ROM address, equals current PC
- instr_i  in  WIDTH  ROM read data for instr_addr_o, same cycle
- ifid_valid_o  out  1  IF/ID holds a real instruction
- ifid_instr_o  out  WIDTH  registered instruction
- ifid_pc_o  out  WIDTH  PC of ifid_instr_o
- ifid_pc4_o  out  WIDTH  ifid_pc_o + 4
- misalign_o  out  1  one-cycle pulse: accepted redirect had target_i[1:0] != 0
- fault_o  out  1  sticky: fetch attempted beyond ROM_BYTES-4
- fetch_cnt_o  out  CNT_W  count of valid instructions loaded into IF/ID

## Operation
- State: PC register, IF/ID register (valid, instr, pc, pc4), fault flag, counter.
- instr_addr_o = PC, combinational from the register; ROM lookup completes in the same cycle.
- Per-edge priority: reset > redirect > fault > stall > advance.
- Reset (rst_n_i=0 at edge): PC=RESET_PC, ifid_valid_o=0, ifid_instr_o=NOP, ifid_pc_o=0, ifid_pc4_o=4, misalign_o=0, fault_o=0, fetch_cnt_o=0.
- Redirect:
  - PC={target_i[WIDTH-1:2],2'b00}.
  - IF/ID loads bubble: valid=0, instr=NOP, pc and pc4 unchanged.
  - misalign_o=1 for the next cycle if target_i[1:0]!=0.
  - Clears fault_o.
  - Overrides stall_i.
- Fault:
  - Out-of-range: PC > ROM_BYTES-4, unsigned compare.
  - If not redirecting and PC is out of range: fault_o set. PC held. IF/ID loads bubble. Counter unchanged. instr_i is ignored.
- Stall (no redirect, no fault): PC, IF/ID, counter all hold.
- Advance:
  - IF/ID = {1, instr_i, PC, PC+4}.
  - PC = PC+4, modulo 2^WIDTH.
  - fetch_cnt_o increments, wrapping at 2^CNT_W.
- PC is always word-aligned; PC+4 beyond ROM_BYTES-4 is legal to compute and faults on the following edge.

## Timing
- Address-to-IF/ID latency: 1 cycle. The word at PC is in ifid_instr_o the cycle after the edge on which it was captured.
- First valid instruction: at reset release, instr_addr_o=RESET_PC in the first cycle with rst_n_i=1. ifid_valid_o=1 after the next edge.
- Redirect penalty: 1 bubble from this stage.
  - Edge N samples redirect_i: PC=target and IF/ID=bubble after edge N.
  - Target instruction is valid after edge N+1.
- Stall has zero latency: outputs are frozen from the edge that samples stall_i=1. stall_i is ignored while fault_o is set.
- Reset asserted mid-stream takes effect at the next edge regardless of stall/redirect. In-flight IF/ID content is discarded.
- misalign_o and fault_o are registered; no combinational path from inputs to outputs except instr_i is captured only at the edge.

## Test plan
- Reset then free-run, RESET_PC=0, ROM words W0..W3 at 0,4,8,C: after reset release, instr_addr_o steps 0,4,8,C on consecutive cycles.
  - IF/ID shows (W0,pc 0),(W1,pc 4)... one cycle later.
  - fetch_cnt_o=4 after four advances.
- Stall for 3 cycles while IF/ID holds (W1,4): PC stays 8, ifid_* unchanged, counter unchanged.
  - On release, next IF/ID is (W2,8).
- Redirect to 0x40 asserted together with stall_i=1 while PC=0x10: PC=0x40, ifid_valid_o=0, ifid_instr_o=NOP.
  - Next cycle IF/ID = (word@0x40, pc 0x40, pc4 0x44).
- Redirect to 0x22: PC=0x20, misalign_o=1 for exactly one cycle, fetch proceeds from 0x20.
- ROM_BYTES=4096, redirect to 0xFFC: IF/ID gets word@0xFFC, then PC=0x1000.
  - fault_o=1 next cycle, ifid_valid_o=0, PC stays 0x1000.
  - A subsequent redirect to 0 clears fault_o and resumes.
- Assert rst_n_i=0 for one cycle mid-run at PC=0x30 with valid IF/ID: all outputs return to reset values at that edge.
  - Fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// RV32I fetch stage: owns the PC, drives the ROM address, registers the ROM word into IF/ID.
// Latency 1 cycle address-to-IF/ID; stall_i freezes PC and IF/ID, and a redirect overrides both stall and fault.
module fetch_stage #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int unsigned      ROM_BYTES = 4096,
  parameter logic [WIDTH-1:0] NOP       = 'h13,
  parameter int unsigned      CNT_W     = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [WIDTH-1:0] target_i,
  output logic [WIDTH-1:0] instr_addr_o,
  input  logic [WIDTH-1:0] instr_i,
  output logic             ifid_valid_o,
  output logic [WIDTH-1:0] ifid_instr_o,
  output logic [WIDTH-1:0] ifid_pc_o,
  output logic [WIDTH-1:0] ifid_pc4_o,
  output logic             misalign_o,
  output logic             fault_o,
  output logic [CNT_W-1:0] fetch_cnt_o
);

  localparam logic [WIDTH-1:0] LAST_PC = WIDTH'(ROM_BYTES - 4);

  logic [WIDTH-1:0] pc;
  logic             pc_oob;

  assign instr_addr_o = pc;
  assign pc_oob       = (pc > LAST_PC);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pc           <= RESET_PC;
      ifid_valid_o <= 1'b0;
      ifid_instr_o <= NOP;
      ifid_pc_o    <= '0;
      ifid_pc4_o   <= WIDTH'(4);
      misalign_o   <= 1'b0;
      fault_o      <= 1'b0;
      fetch_cnt_o  <= '0;
    end else begin
      misalign_o <= 1'b0;
      if (redirect_i) begin
        // Low target bits are dropped; the misalign pulse reports that they were set.
        pc           <= {target_i[WIDTH-1:2], 2'b00};
        ifid_valid_o <= 1'b0;
        ifid_instr_o <= NOP;
        misalign_o   <= |target_i[1:0];
        fault_o      <= 1'b0;
      end else if (pc_oob) begin
        // PC parks here until a redirect; the ROM data is garbage so it is never captured.
        fault_o      <= 1'b1;
        ifid_valid_o <= 1'b0;
        ifid_instr_o <= NOP;
      end else if (!stall_i) begin
        ifid_valid_o <= 1'b1;
        ifid_instr_o <= instr_i;
        ifid_pc_o    <= pc;
        ifid_pc4_o   <= pc + WIDTH'(4);
        pc           <= pc + WIDTH'(4);
        fetch_cnt_o  <= fetch_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: vector table for control/status, queue of expected IF/ID words for captured fetches.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n, stall, redirect;
  logic [31:0] target, instr_addr, instr;
  logic        ifid_valid, misalign, fault;
  logic [31:0] ifid_instr, ifid_pc, ifid_pc4, fetch_cnt;

  logic [7:0] rom [0:4095];

  always #5 clk = ~clk;

  fetch_stage #(
    .WIDTH(32), .RESET_PC(32'h0), .ROM_BYTES(4096), .NOP(32'h00000013), .CNT_W(32)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .stall_i(stall), .redirect_i(redirect), .target_i(target),
    .instr_addr_o(instr_addr), .instr_i(instr),
    .ifid_valid_o(ifid_valid), .ifid_instr_o(ifid_instr), .ifid_pc_o(ifid_pc), .ifid_pc4_o(ifid_pc4),
    .misalign_o(misalign), .fault_o(fault), .fetch_cnt_o(fetch_cnt)
  );

  // Big-endian byte ROM; out-of-range reads return a poison word.
  assign instr = (instr_addr > 32'd4092) ? 32'hBAD0BAD0 :
                 {rom[instr_addr[11:0]], rom[instr_addr[11:0] + 12'd1],
                  rom[instr_addr[11:0] + 12'd2], rom[instr_addr[11:0] + 12'd3]};

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [11:0] i;
    i = a[11:0];
    if (a > 32'd4092) return 32'hBAD0BAD0;
    return {rom[i], rom[i + 12'd1], rom[i + 12'd2], rom[i + 12'd3]};
  endfunction

  typedef struct {
    logic        rst_n, stall, redir;
    logic [31:0] tgt;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_mis, e_fault;
    logic [31:0] e_cnt;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;

  function automatic vec_t mk(input logic r, input logic s, input logic d, input logic [31:0] t,
                              input logic [31:0] a, input logic v, input logic [31:0] p,
                              input logic m, input logic f, input logic [31:0] c);
    vec_t x;
    x.rst_n = r; x.stall = s; x.redir = d; x.tgt = t;
    x.e_addr = a; x.e_valid = v; x.e_pc = p; x.e_mis = m; x.e_fault = f; x.e_cnt = c;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    logic [31:0] prev_addr;
    exp_t        e;
    bit          push;

    for (int i = 0; i < 4096; i++) rom[i] = 8'((i * 37) ^ (i >> 3) ^ 8'h5A);

    //            rst st rd tgt        addr       v  ifid_pc    m  f  cnt
    vt.push_back(mk(0, 0, 0, 32'h0,   32'h0,    0, 32'h0,    0, 0, 0));
    vt.push_back(mk(0, 0, 0, 32'h0,   32'h0,    0, 32'h0,    0, 0, 0));
    vt.push_back(mk(1, 0, 0, 32'h0,   32'h4,    1, 32'h0,    0, 0, 1));
    vt.push_back(mk(1, 0, 0, 32'h0,   32'h8,    1, 32'h4,    0, 0, 2));
    vt.push_back(mk(1, 1, 0, 32'h0,   32'h8,    1, 32'h4,    0, 0, 2));
    vt.push_back(mk(1, 1, 0, 32'h0,   32'h8,    1, 32'h4,    0, 0, 2));
    vt.push_back(mk(1, 1, 0, 32'h0,   32'h8,    1, 32'h4,    0, 0, 2));
    vt.push_back(mk(1, 0, 0, 32'h0,   32'hC,    1, 32'h8,    0, 0, 3));
    vt.push_back(mk(1, 0, 0, 32'h0,   32'h10,   1, 32'hC,    0, 0, 4));
    vt.push_back(mk(1, 1, 1, 32'h40,  32'h40,   0, 32'hC,    0, 0, 4));
    vt.push_back(mk(1, 0, 0, 32'h0,   32'h44,   1, 32'h40,   0, 0, 5));
    vt.push_back(mk(1, 0, 1, 32'h22,  32'h20,   0, 32'h40,   1, 0, 5));
    vt.push_back(mk(1, 0, 0, 32'h0,   32'h24,   1, 32'h20,   0, 0, 6));
    vt.push_back(mk(1, 0, 1, 32'hFFC, 32'hFFC,  0, 32'h20,   0, 0, 6));
    vt.push_back(mk(1, 0, 0, 32'h0,   32'h1000, 1, 32'hFFC,  0, 0, 7));
    vt.push_back(mk(1, 0, 0, 32'h0,   32'h1000, 0, 32'hFFC,  0, 1, 7));
    vt.push_back(mk(1, 1, 0, 32'h0,   32'h1000, 0, 32'hFFC,  0, 1, 7));
    vt.push_back(mk(1, 0, 1, 32'h0,   32'h0,    0, 32'hFFC,  0, 0, 7));
    vt.push_back(mk(1, 0, 0, 32'h0,   32'h4,    1, 32'h0,    0, 0, 8));
    vt.push_back(mk(1, 0, 1, 32'h2C,  32'h2C,   0, 32'h0,    0, 0, 8));
    vt.push_back(mk(1, 0, 0, 32'h0,   32'h30,   1, 32'h2C,   0, 0, 9));
    vt.push_back(mk(0, 1, 1, 32'h80,  32'h0,    0, 32'h0,    0, 0, 0));
    vt.push_back(mk(1, 0, 0, 32'h0,   32'h4,    1, 32'h0,    0, 0, 1));
    vt.push_back(mk(1, 0, 0, 32'h0,   32'h8,    1, 32'h4,    0, 0, 2));

    prev_addr = 32'h0;
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; target = '0;

    foreach (vt[k]) begin
      rst_n = vt[k].rst_n; stall = vt[k].stall; redirect = vt[k].redir; target = vt[k].tgt;
      push = vt[k].rst_n && !vt[k].stall && !vt[k].redir && vt[k].e_valid;
      if (push) begin
        e.instr = rom_word(prev_addr);
        e.pc    = prev_addr;
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
      chk($sformatf("v%0d addr", k),     instr_addr,        vt[k].e_addr);
      chk($sformatf("v%0d valid", k),    32'(ifid_valid),   32'(vt[k].e_valid));
      chk($sformatf("v%0d pc", k),       ifid_pc,           vt[k].e_pc);
      chk($sformatf("v%0d pc4", k),      ifid_pc4,          vt[k].e_pc + 32'd4);
      chk($sformatf("v%0d misalign", k), 32'(misalign),     32'(vt[k].e_mis));
      chk($sformatf("v%0d fault", k),    32'(fault),        32'(vt[k].e_fault));
      chk($sformatf("v%0d cnt", k),      fetch_cnt,         vt[k].e_cnt);
      if (!vt[k].e_valid) begin
        chk($sformatf("v%0d bubble", k), ifid_instr, 32'h00000013);
      end else if (push) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL v%0d scoreboard: got empty queue expected an entry", k);
        end else begin
          e = sb.pop_front();
          chk($sformatf("v%0d sb_instr", k), ifid_instr, e.instr);
          chk($sformatf("v%0d sb_pc", k),    ifid_pc,    e.pc);
        end
      end
      prev_addr = vt[k].e_addr;
    end

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
